// File: rtl/sci_pkg.sv
// sci_pkg: shared definitions for the SCI UART with FIFOs.
//   Register offsets on the CPU I/O window, STAT/CTRL bit positions,
//   bit-timing constants and the TX/RX state encodings.
package sci_pkg;

  // Register offsets within the I/O window
  localparam int REG_DATA = 0;
  localparam int REG_STAT = 1;
  localparam int REG_CTRL = 2;

  // STAT bit positions
  localparam int STAT_RX_AVAIL  = 0;
  localparam int STAT_TX_NFULL  = 1;
  localparam int STAT_TX_IDLE   = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR = 4;

  // CTRL bit positions
  localparam int CTRL_RXIE  = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_CLEAR = 2;

  // Bit timing in baud ticks: a bit is 16 ticks, the start-bit check sits at tick 8
  localparam logic [3:0] LAST_TICK = 4'd15;
  localparam logic [3:0] MID_TICK  = 4'd7;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/sci_uart_fifo_if.sv
// sci_uart_fifo_if: CPU-side I/O window of the SCI.
//   sel   I/O window select        addr  register offset
//   rd    CPU read level           wr    CPU write level
//   din   write data from CPU      dout  read data to CPU
//   irq   receive interrupt request
// The CPU (or bench) uses the master modport, the SCI the slave modport.
interface sci_uart_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);

  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              irq;

  modport master (
    output sel, addr, rd, wr, din,
    input  dout, irq
  );

  modport slave (
    input  sel, addr, rd, wr, din,
    output dout, irq
  );

endinterface

// File: rtl/sci_sync_fifo.sv
// sci_sync_fifo: single-clock FIFO used for both the TX and RX queues.
//   clk50  clock               reset  synchronous active-high, empties the FIFO
//   push   write request       wdata  data to write
//   pop    read request        rdata  current head (valid when not empty)
//   empty  no entries          full   DEPTH entries held
// Pointers carry one extra wrap bit so full and empty can be told apart.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty does nothing.
module sci_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[IDX_W-1:0]];

  // Storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk50) begin
    if (do_push) begin
      mem[wr_ptr[IDX_W-1:0]] <= wdata;
    end
  end

  // Pointers wrap naturally modulo 2*DEPTH
  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sci_uart_fifo.sv
// sci_uart_fifo: memory-mapped asynchronous serial port with RX/TX FIFOs.
//   clk50  system clock            reset  synchronous active-high
//   bus    CPU I/O window (slave): sel, addr, rd, wr, din, dout, irq
//   rxd    serial input (asynchronous)
//   txd    serial output, idles high
// Registers: 0 DATA (read RX head / write TX push), 1 STAT, 2 CTRL,
// all other offsets read 0 and ignore writes.
module sci_uart_fifo
  import sci_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int BAUD_DIV = 326,
  parameter int ADDR_W   = 3
) (
  input  logic           clk50,
  input  logic           reset,
  sci_uart_fifo_if.slave bus,
  input  logic           rxd,
  output logic           txd
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  // CPU strobe decode
  logic hit_data;
  logic hit_stat;
  logic hit_ctrl;
  logic rd_lvl;
  logic rd_q;
  logic wr_lvl;
  logic wr_q;
  logic wr_rise;
  logic tx_push;
  logic rx_pop;
  logic ctrl_wr;

  // Control and sticky flags
  logic rxie;
  logic loop_en;
  logic overrun;
  logic frame_err;

  // FIFO connections
  logic [DATA_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_full;
  logic              tx_pop;
  logic [DATA_W-1:0] rx_head;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_push;
  logic              rx_ferr;

  // Transmitter
  tx_state_t         tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [3:0]        tx_ticks;
  logic [BIT_W-1:0]  tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_tick;
  logic              tx_bit_end;

  // Receiver
  rx_state_t         rx_state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [3:0]        rx_ticks;
  logic [BIT_W-1:0]  rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_in;
  logic              rx_s1;
  logic              rx_s2;
  logic              rx_s3;
  logic              rx_fall;
  logic              rx_tick;
  logic              rx_bit_end;

  // Read mux
  logic [DATA_W-1:0] stat_word;
  logic [DATA_W-1:0] rd_data;

  assign hit_data = (bus.addr == ADDR_W'(REG_DATA));
  assign hit_stat = (bus.addr == ADDR_W'(REG_STAT));
  assign hit_ctrl = (bus.addr == ADDR_W'(REG_CTRL));

  // The DATA pop is held back until the read level drops, so the CPU sees
  // a stable head for the whole read; writes act on the rising edge.
  assign rd_lvl  = bus.sel & bus.rd & hit_data;
  assign wr_lvl  = bus.sel & bus.wr;
  assign wr_rise = wr_lvl & ~wr_q;
  assign tx_push = wr_rise & hit_data;
  assign ctrl_wr = wr_rise & hit_ctrl;
  assign rx_pop  = rd_q & ~rd_lvl;

  // Previous-cycle copies of the CPU strobes for edge detection
  always_ff @(posedge clk50) begin
    if (reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd_lvl;
      wr_q <= wr_lvl;
    end
  end

  sci_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk50 (clk50),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus.din),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  sci_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk50 (clk50),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_shift),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // CTRL register and sticky error flags; a flag set in the same cycle as
  // a clear request wins because its assignment comes last.
  always_ff @(posedge clk50) begin
    if (reset) begin
      rxie      <= 1'b0;
      loop_en   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rxie    <= bus.din[CTRL_RXIE];
        loop_en <= bus.din[CTRL_LOOP];
        if (bus.din[CTRL_CLEAR]) begin
          overrun   <= 1'b0;
          frame_err <= 1'b0;
        end
      end
      if (rx_ferr) begin
        frame_err <= 1'b1;
      end
      if (rx_push && rx_full && !rx_pop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Transmitter. The baud counter is held at zero while idle and free-runs
  // for the whole frame, so every bit spans exactly 16*BAUD_DIV cycles.
  assign tx_tick    = (tx_cnt == CNT_MAX);
  assign tx_bit_end = tx_tick && (tx_ticks == LAST_TICK);
  assign tx_pop     = (tx_state == TX_IDLE) && !tx_empty;

  always_ff @(posedge clk50) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_ticks <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt   <= '0;
      tx_ticks <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
      if (!tx_empty) begin
        tx_shift <= tx_head;
        txd      <= 1'b0;
        tx_state <= TX_START;
      end
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + CNT_W'(1);
      if (tx_tick) begin
        tx_ticks <= tx_ticks + 4'd1;
      end
      if (tx_bit_end) begin
        case (tx_state)
          TX_START: begin
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
              tx_bit   <= tx_bit + BIT_W'(1);
            end
          end
          default: begin
            tx_state <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // Receive line selection and 2-flop synchroniser; rx_s3 is only the
  // previous synchronised value used to spot the start edge.
  assign rx_in   = loop_en ? txd : rxd;
  assign rx_fall = rx_s3 & ~rx_s2;

  always_ff @(posedge clk50) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver. The baud counter restarts on the start edge so samples land
  // mid-bit: the start bit is checked after 8 ticks, every later bit 16
  // ticks apart. A completed character is pushed (or flagged) at mid-stop.
  assign rx_tick    = (rx_cnt == CNT_MAX);
  assign rx_bit_end = rx_tick && (rx_ticks == LAST_TICK);
  assign rx_push    = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
  assign rx_ferr    = (rx_state == RX_STOP) && rx_bit_end && !rx_s2;

  always_ff @(posedge clk50) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_ticks <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt   <= '0;
      rx_ticks <= '0;
      rx_bit   <= '0;
      if (rx_fall) begin
        rx_state <= RX_START;
      end
    end else begin
      rx_cnt <= rx_tick ? '0 : rx_cnt + CNT_W'(1);
      if (rx_tick) begin
        rx_ticks <= rx_ticks + 4'd1;
      end
      case (rx_state)
        RX_START: begin
          if (rx_tick && (rx_ticks == MID_TICK)) begin
            rx_ticks <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + BIT_W'(1);
            end
          end
        end
        default: begin
          if (rx_bit_end) begin
            rx_state <= RX_IDLE;
          end
        end
      endcase
    end
  end

  // Status word and combinational read mux
  always_comb begin
    stat_word                 = '0;
    stat_word[STAT_RX_AVAIL]  = ~rx_empty;
    stat_word[STAT_TX_NFULL]  = ~tx_full;
    stat_word[STAT_TX_IDLE]   = tx_empty && (tx_state == TX_IDLE);
    stat_word[STAT_OVERRUN]   = overrun;
    stat_word[STAT_FRAME_ERR] = frame_err;
  end

  always_comb begin
    rd_data = '0;
    if (bus.sel && bus.rd) begin
      if (hit_data) begin
        rd_data = rx_empty ? '0 : rx_head;
      end else if (hit_stat) begin
        rd_data = stat_word;
      end else if (hit_ctrl) begin
        rd_data[CTRL_RXIE] = rxie;
        rd_data[CTRL_LOOP] = loop_en;
      end
    end
  end

  assign bus.dout = rd_data;
  assign bus.irq  = ~rx_empty & rxie;

endmodule

// File: tb/tb_sci_uart_fifo.sv
// tb_sci_uart_fifo: self-checking bench for sci_uart_fifo.
// A behavioural model (queues plus sticky flag bits) predicts every CPU
// read; a txd decoder turns the serial output back into characters.
module tb_sci_uart_fifo;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int BAUD_DIV = 4;
  localparam int ADDR_W   = 3;
  localparam int BIT      = 16 * BAUD_DIV;
  localparam int CLK_NS   = 20;

  logic clk50 = 1'b0;
  logic reset;
  logic rxd;
  logic txd;

  int checks = 0;
  int errors = 0;

  byte unsigned rxModel[$];
  bit           overrunModel = 1'b0;
  bit           frameModel   = 1'b0;
  byte unsigned txSeen[$];
  int           txStopBad = 0;
  longint       txEdges[$];

  sci_uart_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sci_uart_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .BAUD_DIV (BAUD_DIV),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #(CLK_NS / 2) clk50 = ~clk50;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Model: expected STAT whenever the transmitter has drained
  function automatic logic [7:0] statModel();
    return {3'b000, frameModel, overrunModel, 1'b1, 1'b1, rxModel.size() != 0};
  endfunction

  // Model: a well-formed character arriving at the receiver
  function automatic void modelRxChar(input byte unsigned ch);
    if (rxModel.size() < DEPTH) rxModel.push_back(ch);
    else overrunModel = 1'b1;
  endfunction

  task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk50);
    bus.sel = 1'b1; bus.addr = a; bus.din = d; bus.wr = 1'b1;
    repeat (4) @(negedge clk50);
    bus.wr = 1'b0; bus.sel = 1'b0;
    repeat (2) @(negedge clk50);
  endtask

  task automatic busRead(input logic [2:0] a, input int hold, output logic [7:0] d);
    @(negedge clk50);
    bus.sel = 1'b1; bus.addr = a; bus.rd = 1'b1;
    @(negedge clk50);
    d = bus.dout;
    repeat (hold) @(negedge clk50);
    bus.rd = 1'b0; bus.sel = 1'b0;
    repeat (2) @(negedge clk50);
  endtask

  task automatic readData(input string tag, input int hold);
    logic [7:0] d;
    logic [7:0] exp;
    busRead(3'(0), hold, d);
    exp = (rxModel.size() != 0) ? rxModel.pop_front() : 8'h00;
    checkOutput(tag, 32'(d), 32'(exp));
  endtask

  task automatic readStat(input string tag);
    logic [7:0] d;
    busRead(3'(1), 2, d);
    checkOutput(tag, 32'(d), 32'(statModel()));
  endtask

  task automatic checkTxChar(input string tag, input logic [7:0] exp);
    if (txSeen.size() == 0) checkOutput({tag, "_present"}, 32'(txSeen.size()), 32'd1);
    else checkOutput(tag, 32'(txSeen.pop_front()), 32'(exp));
  endtask

  // Drive one serial character on rxd and update the model
  task automatic applyStimulus(input logic [7:0] ch, input bit stopGood);
    @(negedge clk50);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk50);
    for (int i = 0; i < 8; i++) begin
      rxd = ch[i];
      repeat (BIT) @(negedge clk50);
    end
    rxd = stopGood;
    repeat (BIT) @(negedge clk50);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk50);
    if (stopGood) modelRxChar(ch);
    else frameModel = 1'b1;
  endtask

  // Record every txd transition time for bit-length measurement
  always @(txd) txEdges.push_back($time);

  // Serial decoder on txd: mid-bit sampling from the start edge
  initial begin
    logic       txPrev;
    logic [7:0] ch;
    txPrev = 1'b1;
    forever begin
      @(negedge clk50);
      if (reset !== 1'b1 && txPrev === 1'b1 && txd === 1'b0) begin
        repeat (BIT / 2) @(negedge clk50);
        ch = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk50);
          ch[i] = txd;
        end
        repeat (BIT) @(negedge clk50);
        if (txd !== 1'b1) txStopBad++;
        txSeen.push_back(ch);
      end
      txPrev = txd;
    end
  end

  initial begin
    repeat (80000) @(posedge clk50);
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] d;
    logic [7:0] ch;
    byte unsigned txExp[$];
    int waited;
    int n;

    bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.din = '0;
    rxd = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);

    $display("[TB] reset state");
    busRead(3'(1), 2, d);
    checkOutput("reset_stat", 32'(d), 32'h06);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_irq", 32'(bus.irq), 32'd0);
    busRead(3'(2), 2, d);
    checkOutput("reset_ctrl", 32'(d), 32'h00);
    busRead(3'(5), 2, d);
    checkOutput("unused_reg", 32'(d), 32'h00);

    $display("[TB] single transmit 0x55");
    txEdges.delete();
    busWrite(3'(0), 8'h55);
    busRead(3'(1), 2, d);
    checkOutput("tx_busy_stat", 32'(d), 32'h02);
    waited = 0;
    while (txEdges.size() < 10 && waited < 20 * BIT) begin
      @(negedge clk50);
      waited++;
    end
    checkOutput("tx55_edges", 32'(txEdges.size()), 32'd10);
    for (int i = 1; i < 10 && i < txEdges.size(); i++)
      checkOutput($sformatf("tx55_bit%0d_len", i - 1),
                  32'((txEdges[i] - txEdges[i-1]) / CLK_NS), 32'(BIT));
    repeat (BIT + 4) @(negedge clk50);
    readStat("tx_idle_after_stop");
    checkTxChar("tx55_char", 8'h55);

    $display("[TB] loopback three chars");
    busWrite(3'(2), 8'h03);
    for (int i = 0; i < 3; i++) begin
      ch = 8'h41 + 8'(i);
      busWrite(3'(0), ch);
      modelRxChar(ch);
    end
    waited = 0;
    while (txSeen.size() < 3 && waited < 40 * BIT) begin
      @(negedge clk50);
      waited++;
    end
    repeat (BIT) @(negedge clk50);
    checkOutput("loop_irq_set", 32'(bus.irq), 32'd1);
    readStat("loop_stat");
    for (int i = 0; i < 3; i++) readData($sformatf("loop_rx%0d", i), 2);
    readStat("loop_stat_empty");
    checkOutput("loop_irq_clear", 32'(bus.irq), 32'd0);
    for (int i = 0; i < 3; i++) checkTxChar($sformatf("loop_tx%0d", i), 8'h41 + 8'(i));
    busWrite(3'(2), 8'h00);

    $display("[TB] random receive with overrun");
    for (int k = 0; k <= DEPTH; k++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    readStat("ovr_stat");
    busWrite(3'(2), 8'h04);
    overrunModel = 1'b0;
    readStat("ovr_clear_stat");
    for (int k = 0; k <= DEPTH; k++) readData($sformatf("ovr_rx%0d", k), 2);
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) readData($sformatf("rand_r%0d_rx%0d", r, k), 2);
      readStat($sformatf("rand_r%0d_stat", r));
    end
    busWrite(3'(2), 8'h04);
    overrunModel = 1'b0;
    while (rxModel.size() != 0) readData("rand_drain", 2);
    readStat("rand_final_stat");

    $display("[TB] framing error and glitch");
    applyStimulus(8'($urandom_range(0, 255)), 1'b0);
    readStat("frame_stat");
    busWrite(3'(2), 8'h04);
    frameModel = 1'b0;
    readStat("frame_clear_stat");
    @(negedge clk50);
    rxd = 1'b0;
    repeat (4 * BAUD_DIV) @(negedge clk50);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk50);
    readStat("glitch_stat");
    applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    readData("post_glitch_rx", 2);

    $display("[TB] long read and full transmit FIFO");
    for (int k = 0; k < 2; k++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    readData("long_read", 99);
    readData("after_long_read", 2);
    readStat("after_long_stat");
    txSeen.delete();
    for (int k = 0; k < DEPTH + 3; k++) begin
      ch = 8'($urandom_range(0, 255));
      busWrite(3'(0), ch);
      if (k < DEPTH + 1) txExp.push_back(ch);
    end
    busRead(3'(1), 2, d);
    checkOutput("txfull_stat", 32'(d), 32'h00);
    waited = 0;
    while (txSeen.size() < DEPTH + 1 && waited < (DEPTH + 3) * 12 * BIT) begin
      @(negedge clk50);
      waited++;
    end
    repeat (2 * BIT) @(negedge clk50);
    checkOutput("txfull_count", 32'(txSeen.size()), 32'(DEPTH + 1));
    for (int k = 0; k < DEPTH + 1; k++) checkTxChar($sformatf("txfull_char%0d", k), txExp[k]);
    readStat("txfull_done_stat");
    checkOutput("tx_stop_bits", 32'(txStopBad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
